deshifter: RTL and testbench

- Receive-side counterpart of the message shifter: collects a stream of KEY_SIZE-bit chunks and reassembles one MSG_SIZE-bit message.
- Sits after the key-XOR stage on the decrypt path. It rebuilds the plaintext/ciphertext word that the shifter serialized, MSB chunk first.
- Valid/ready handshake on both sides; holds the completed message until the consumer takes it.

---
 rtl/otp_pkg.sv | 15 +
 rtl/deshifter.sv | 76 +++++++
 tb/tb_deshifter.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/otp_pkg.sv
// Shared widths and state encoding for the message shifter/deshifter pair.
// Both ends import this so chunk width, message width and chunk order agree.
package otp_pkg;

  localparam int KEY_SIZE = 16;
  localparam int MSG_SIZE = 240;
  localparam int CHUNKS   = MSG_SIZE / KEY_SIZE;
  localparam int CNT_W    = $clog2(CHUNKS + 1);

  typedef enum logic {
    COLLECT = 1'b0,
    FULL    = 1'b1
  } otp_state_e;

endpackage

// File: rtl/deshifter.sv
// Receive-side deshifter: collects CHUNKS key-width chunks (MSB chunk first)
// and presents the reassembled message until the consumer takes it.
//
// state   | meaning
// --------+---------------------------------------------------------------
// COLLECT | accepting chunks; msg shifts left by one chunk per accept
// FULL    | complete message held on msg with msg_valid=1; input stalled
module deshifter
  import otp_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                clear,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [KEY_SIZE-1:0] in_chunk,
  output logic                msg_valid,
  input  logic                msg_ready,
  output logic [MSG_SIZE-1:0] msg,
  output logic [CNT_W-1:0]    count
);

  // A message that is not a whole number of chunks cannot be rebuilt.
  if ((MSG_SIZE % KEY_SIZE) != 0) begin : g_size_check
    $error("deshifter: MSG_SIZE must be a multiple of KEY_SIZE");
  end

  localparam logic [CNT_W-1:0] LAST_IDX   = CNT_W'(CHUNKS - 1);
  localparam logic [CNT_W-1:0] CHUNKS_CNT = CNT_W'(CHUNKS);

  otp_state_e state;

  // Ready depends on state only, so the release cycle never accepts a chunk.
  assign in_ready = (state == COLLECT);

  // Collect/hold FSM with the shift register and chunk counter inline.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= COLLECT;
      msg       <= '0;
      msg_valid <= 1'b0;
      count     <= '0;
    end else if (clear) begin
      // msg is left as-is; the next message overwrites it by shifting.
      state     <= COLLECT;
      msg_valid <= 1'b0;
      count     <= '0;
    end else begin
      case (state)
        COLLECT: begin
          if (in_valid) begin
            msg <= {msg[MSG_SIZE-KEY_SIZE-1:0], in_chunk};
            if (count == LAST_IDX) begin
              state     <= FULL;
              msg_valid <= 1'b1;
              count     <= CHUNKS_CNT;
            end else begin
              count <= count + 1'b1;
            end
          end
        end
        FULL: begin
          if (msg_ready) begin
            state     <= COLLECT;
            msg_valid <= 1'b0;
            count     <= '0;
          end
        end
        default: begin
          state <= COLLECT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_deshifter.sv
// Self-checking bench for deshifter: expected messages go into a scoreboard
// queue as their chunks are driven and are popped when msg_valid rises.
module tb_deshifter;
  import otp_pkg::*;

  logic                clk = 1'b0;
  logic                reset, clear, in_valid, in_ready, msg_valid, msg_ready;
  logic [KEY_SIZE-1:0] in_chunk;
  logic [MSG_SIZE-1:0] msg;
  logic [CNT_W-1:0]    count;

  int n_checks = 0;
  int n_errors = 0;
  int exp_count = 0;
  logic [MSG_SIZE-1:0] sb_q[$];

  logic [MSG_SIZE-1:0] msg_s1;
  logic [MSG_SIZE-1:0] msg_s4;
  logic [MSG_SIZE-1:0] tmp;
  logic [MSG_SIZE-1:0] held;

  deshifter dut (
    .clk       (clk),
    .reset     (reset),
    .clear     (clear),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_chunk  (in_chunk),
    .msg_valid (msg_valid),
    .msg_ready (msg_ready),
    .msg       (msg),
    .count     (count)
  );

  always #5 clk = ~clk;

  // Compare one observed value against its expectation.
  task automatic check(input string tag, input logic [MSG_SIZE-1:0] obs,
                       input logic [MSG_SIZE-1:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    exp_count = 0;
  endtask

  // Drive one chunk and hold it until accepted (bounded wait on in_ready).
  task automatic send_chunk(input logic [KEY_SIZE-1:0] c);
    int guard;
    guard = 0;
    in_valid = 1'b1;
    in_chunk = c;
    while (!in_ready && guard < 50) begin
      tick();
      guard++;
    end
    if (!in_ready) check("ready_timeout", 0, 1);
    tick();
    in_valid = 1'b0;
    exp_count++;
  endtask

  // Pop the scoreboard and compare against the completed message.
  task automatic expect_full(input string tag);
    logic [MSG_SIZE-1:0] e;
    check({tag, "_valid"}, MSG_SIZE'(msg_valid), 1);
    check({tag, "_count"}, MSG_SIZE'(count), CHUNKS);
    check({tag, "_in_ready"}, MSG_SIZE'(in_ready), 0);
    if (sb_q.size() == 0) begin
      check({tag, "_sb_empty"}, 0, 1);
    end else begin
      e = sb_q.pop_front();
      check({tag, "_msg"}, msg, e);
    end
  endtask

  task automatic release_msg(input string tag);
    msg_ready = 1'b1;
    tick();
    msg_ready = 1'b0;
    exp_count = 0;
    check({tag, "_rel_valid"}, MSG_SIZE'(msg_valid), 0);
    check({tag, "_rel_count"}, MSG_SIZE'(count), 0);
    check({tag, "_rel_ready"}, MSG_SIZE'(in_ready), 1);
  endtask

  initial begin
    logic [MSG_SIZE-1:0] sh;
    int k, guard;
    logic rdy;

    reset = 1'b0; clear = 1'b0; in_valid = 1'b0; msg_ready = 1'b0;
    in_chunk = '0;
    msg_s1 = 240'hABCDEF0123456789ABCDEF0123456789ABCDEF0123456789ABCDEF012345;
    msg_s4 = '0;
    for (int i = 1; i <= CHUNKS; i++) msg_s4 = {msg_s4[MSG_SIZE-KEY_SIZE-1:0], KEY_SIZE'(i)};

    // Scenario 1: reset state, then back-to-back chunks
    do_reset();
    check("rst_msg", msg, 0);
    check("rst_valid", MSG_SIZE'(msg_valid), 0);
    check("rst_count", MSG_SIZE'(count), 0);
    check("rst_ready", MSG_SIZE'(in_ready), 1);
    sb_q.push_back(msg_s1);
    for (int i = 0; i < CHUNKS; i++) begin
      tmp = msg_s1 << (i * KEY_SIZE);
      send_chunk(tmp[MSG_SIZE-1 -: KEY_SIZE]);
      if (i < CHUNKS - 1) begin
        check("s1_count", MSG_SIZE'(count), MSG_SIZE'(exp_count));
        check("s1_not_valid", MSG_SIZE'(msg_valid), 0);
      end
    end
    expect_full("s1");

    // Scenario 2: hold while input keeps offering FFFF, then release
    held = msg;
    in_valid = 1'b1;
    in_chunk = 16'hFFFF;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("s2_hold_msg", msg, held);
      check("s2_hold_count", MSG_SIZE'(count), CHUNKS);
      check("s2_hold_valid", MSG_SIZE'(msg_valid), 1);
    end
    release_msg("s2");
    check("s2_no_bypass_msg", msg, held);
    in_valid = 1'b0;

    // Scenario 3: msg_ready without msg_valid does nothing; gapped chunks
    msg_ready = 1'b1;
    tick(); tick();
    msg_ready = 1'b0;
    check("s3_idle_ready_count", MSG_SIZE'(count), 0);
    check("s3_idle_ready_in", MSG_SIZE'(in_ready), 1);
    sb_q.push_back(msg_s1);
    for (int i = 0; i < CHUNKS; i++) begin
      tmp = msg_s1 << (i * KEY_SIZE);
      send_chunk(tmp[MSG_SIZE-1 -: KEY_SIZE]);
      if (i < CHUNKS - 1) begin
        check("s3_count_acc", MSG_SIZE'(count), MSG_SIZE'(exp_count));
        tick(); tick();
        check("s3_count_gap", MSG_SIZE'(count), MSG_SIZE'(exp_count));
      end
    end
    expect_full("s3");
    release_msg("s3");

    // Scenario 4: reset mid-message, then 0001..000F
    for (int i = 0; i < 7; i++) send_chunk(16'h5A5A);
    check("s4_partial_count", MSG_SIZE'(count), 7);
    do_reset();
    check("s4_rst_msg", msg, 0);
    check("s4_rst_count", MSG_SIZE'(count), 0);
    check("s4_rst_valid", MSG_SIZE'(msg_valid), 0);
    sb_q.push_back(msg_s4);
    for (int i = 1; i <= CHUNKS; i++) send_chunk(KEY_SIZE'(i));
    expect_full("s4");
    release_msg("s4");

    // Scenario 5: clear after 5 chunks drops the same-cycle chunk
    for (int i = 0; i < 5; i++) send_chunk(KEY_SIZE'(16'hC000 + i));
    clear = 1'b1;
    in_valid = 1'b1;
    in_chunk = 16'h1234;
    tick();
    clear = 1'b0;
    in_valid = 1'b0;
    exp_count = 0;
    check("s5_clr_count", MSG_SIZE'(count), 0);
    check("s5_clr_valid", MSG_SIZE'(msg_valid), 0);
    check("s5_clr_msg_kept", MSG_SIZE'(msg[5*KEY_SIZE-1:0]),
          MSG_SIZE'(80'hC000_C001_C002_C003_C004));
    tmp = '0;
    for (int i = 0; i < CHUNKS; i++) tmp = {tmp[MSG_SIZE-KEY_SIZE-1:0], KEY_SIZE'($urandom)};
    sb_q.push_back(tmp);
    sh = tmp;
    for (int i = 0; i < CHUNKS; i++) begin
      send_chunk(sh[MSG_SIZE-1 -: KEY_SIZE]);
      sh = sh << KEY_SIZE;
    end
    expect_full("s5");

    // Simultaneous reset and clear behaves as reset
    clear = 1'b1;
    do_reset();
    clear = 1'b0;
    check("rc_msg", msg, 0);
    check("rc_valid", MSG_SIZE'(msg_valid), 0);
    check("rc_count", MSG_SIZE'(count), 0);

    // Scenario 6: loopback from a behavioural shifter with random valid
    sb_q.push_back(msg_s1);
    sh = msg_s1;
    k = 0;
    guard = 0;
    while (k < CHUNKS && guard < 400) begin
      in_valid = 1'($urandom_range(0, 1));
      in_chunk = sh[MSG_SIZE-1 -: KEY_SIZE];
      rdy = in_ready;
      tick();
      if (in_valid && rdy) begin
        sh = sh << KEY_SIZE;
        k++;
      end
      guard++;
    end
    in_valid = 1'b0;
    if (k < CHUNKS) check("s6_timeout", MSG_SIZE'(k), CHUNKS);
    expect_full("s6");
    release_msg("s6");

    check("sb_drained", MSG_SIZE'(sb_q.size()), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
